// File: rtl/bch_chien_serial.sv
// bch_chien_serial: serial Chien search, one error flag per codeword bit from position N-1 down to 0.
// Define BCH_CHIEN_FAIL_EN to add the found-error counter and the uncorrectable (fail) flag.
`ifndef BCH_SANE
`define BCH_SANE {16'd15, 8'd2, 8'd4}
`define BCH_M(P) ((P) % 256)
`define BCH_T(P) (((P) >> 8) % 256)
`define BCH_N(P) ((P) >> 16)
`define BCH_SIGMA_SZ(P) ((`BCH_T(P) + 1) * `BCH_M(P))
`define BCH_ERR_SZ(P) ($clog2(`BCH_T(P) + 2))
`endif

module bch_chien_serial #(
    parameter logic [31:0] P = `BCH_SANE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sigma_done,
    input  logic [`BCH_SIGMA_SZ(P)-1:0] sigma,
    input  logic [`BCH_ERR_SZ(P)-1:0]   err_count,
    output logic                        ack_done,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic                        err,
    output logic                        last,
    output logic                        fail
);
    localparam int M  = `BCH_M(P);
    localparam int T  = `BCH_T(P);
    localparam int N  = `BCH_N(P);
    localparam int EW = `BCH_ERR_SZ(P);
    localparam int PW = $clog2(N + 1);
    localparam logic [PW-1:0] POS_FIRST = PW'(N - 1);

    function automatic logic [16:0] prim_poly(input int m);
        case (m)
            2:       return 17'h00007;
            3:       return 17'h0000B;
            4:       return 17'h00013;
            5:       return 17'h00025;
            6:       return 17'h00043;
            7:       return 17'h00089;
            8:       return 17'h0011D;
            9:       return 17'h00211;
            10:      return 17'h00409;
            11:      return 17'h00805;
            12:      return 17'h01053;
            13:      return 17'h0201B;
            14:      return 17'h04443;
            15:      return 17'h08003;
            default: return 17'h1100B;
        endcase
    endfunction

    localparam logic [16:0]  POLY_FULL = prim_poly(M);
    localparam logic [M-1:0] POLY      = POLY_FULL[M-1:0];

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] x;
        r = '0;
        x = a;
        for (int k = 0; k < M; k++) begin
            if (b[k]) r = r ^ x;
            x = x[M-1] ? ((x << 1) ^ POLY) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [M-1:0] gf_pow(input int e);
        logic [M-1:0] r;
        r = M'(1);
        for (int k = 0; k < e; k++) r = gf_mul(r, M'(2));
        return r;
    endfunction

    // load constants rewind the evaluation point to alpha^-(N-1); step constants advance it by alpha
    function automatic logic [T:0][M-1:0] gf_consts(input logic load);
        logic [T:0][M-1:0] c;
        for (int i = 0; i <= T; i++)
            c[i] = gf_pow(load ? (i * ((1 << M) - N)) % ((1 << M) - 1) : i);
        return c;
    endfunction

    localparam logic [T:0][M-1:0] LOAD_C = gf_consts(1'b1);
    localparam logic [T:0][M-1:0] STEP_C = gf_consts(1'b0);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            state_q, state_d;
    logic [T:0][M-1:0] term_q, term_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [M-1:0]      eval;
    logic              accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            term_q  <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ack_done ? LOAD : IDLE;
            LOAD:    state_d = RUN;
            default: state_d = (accept && last) ? IDLE : RUN;
        endcase
    end

    always_comb begin
        term_d = term_q;
        pos_d  = pos_q;
        if (ack_done) begin
            term_d = sigma;
        end else if (state_q == LOAD) begin
            for (int i = 0; i <= T; i++) term_d[i] = gf_mul(term_q[i], LOAD_C[i]);
            pos_d = POS_FIRST;
        end else if (accept) begin
            for (int i = 0; i <= T; i++) term_d[i] = gf_mul(term_q[i], STEP_C[i]);
            pos_d = pos_q - 1'b1;
        end
    end

`ifdef BCH_CHIEN_FAIL_EN
    localparam logic [EW-1:0] T_E  = EW'(T);
    localparam logic [EW-1:0] T1_E = EW'(T + 1);

    logic [EW-1:0] cnt_q, cnt_d, ec_q, ec_d, found;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ec_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            ec_q  <= ec_d;
        end
    end

    always_comb begin
        found = (err && cnt_q != T1_E) ? cnt_q + 1'b1 : cnt_q;
        cnt_d = ack_done ? '0 : (accept ? found : cnt_q);
        ec_d  = ack_done ? err_count : ec_q;
    end
`else
    logic unused_err_count;
    assign unused_err_count = ^err_count;
`endif

    always_comb begin
        eval = '0;
        for (int i = 0; i <= T; i++) eval = eval ^ term_q[i];
        ack_done  = sigma_done && state_q == IDLE && !reset;
        out_valid = state_q == RUN && !reset;
        err       = out_valid && eval == '0;
        last      = out_valid && pos_q == '0;
        accept    = out_valid && out_ready;
`ifdef BCH_CHIEN_FAIL_EN
        fail      = last && (found != ec_q || ec_q > T_E);
`else
        fail      = 1'b0;
`endif
    end
endmodule

// File: tb/tb_bch_chien_serial.sv
// tb_bch_chien_serial: directed BCH(15,7) vectors (x^4+x+1, T=2) with hand-derived error positions.
module tb_bch_chien_serial;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sigma_done = 1'b0;
    logic        out_ready = 1'b1;
    logic [11:0] sigma = '0;
    logic [1:0]  err_count = '0;
    logic        ack_done, out_valid, err, last, fail;
    int          n_checks = 0;
    int          n_errors = 0;

`ifdef BCH_CHIEN_FAIL_EN
    localparam logic FAIL_EXP = 1'b1;
`else
    localparam logic FAIL_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    bch_chien_serial dut (
        .clk(clk), .reset(reset), .sigma_done(sigma_done), .sigma(sigma),
        .err_count(err_count), .ack_done(ack_done), .out_ready(out_ready),
        .out_valid(out_valid), .err(err), .last(last), .fail(fail)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // call at a falling edge with the block idle; returns just after the falling edge following the last beat
    task automatic run_case(input string name, input logic [11:0] s, input logic [1:0] ec,
                            input logic [14:0] emask, input logic efail, input int stall_at, input int stall_len);
        sigma = s;
        err_count = ec;
        sigma_done = 1'b1;
        #1;
        check({name, ".ack"}, ack_done, 1);
        check({name, ".ack_valid"}, out_valid, 0);
        @(negedge clk);
        sigma_done = 1'b0;
        #1;
        check({name, ".load_ack"}, ack_done, 0);
        check({name, ".load_valid"}, out_valid, 0);
        @(negedge clk);
        for (int k = 0; k < 15; k++) begin
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int j = 0; j < stall_len; j++) begin
                    #1;
                    check($sformatf("%s.stall%0d_valid", name, j), out_valid, 1);
                    check($sformatf("%s.stall%0d_err", name, j), err, emask[k]);
                    check($sformatf("%s.stall%0d_last", name, j), last, 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            #1;
            check($sformatf("%s.b%0d_valid", name, k), out_valid, 1);
            check($sformatf("%s.b%0d_err", name, k), err, emask[k]);
            check($sformatf("%s.b%0d_last", name, k), last, k == 14);
            if (k == 14) check({name, ".fail"}, fail, efail);
            @(negedge clk);
        end
        #1;
        check({name, ".idle_valid"}, out_valid, 0);
        check({name, ".idle_last"}, last, 0);
    endtask

    initial begin
        sigma_done = 1'b1;
        sigma = 12'h671;
        repeat (2) @(negedge clk);
        #1;
        check("rst.ack", ack_done, 0);
        check("rst.valid", out_valid, 0);
        check("rst.err", err, 0);
        check("rst.last", last, 0);
        check("rst.fail", fail, 0);
        @(negedge clk);
        reset = 1'b0;
        sigma_done = 1'b0;
        @(negedge clk);
        run_case("none", 12'h001, 2'd0, 15'h0000, 1'b0, -1, 0);
        run_case("one", 12'h081, 2'd1, 15'h0800, 1'b0, -1, 0);
        run_case("two", 12'h671, 2'd2, 15'h4200, 1'b0, -1, 0);
        run_case("mismatch", 12'h081, 2'd2, 15'h0800, FAIL_EXP, -1, 0);
        run_case("stall", 12'h671, 2'd2, 15'h4200, 1'b0, 4, 3);
        // abort a run at beat 6 with sigma_done held high throughout
        @(negedge clk);
        sigma = 12'h671;
        err_count = 2'd2;
        sigma_done = 1'b1;
        #1;
        check("abort.ack", ack_done, 1);
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("abort.b%0d_valid", k), out_valid, 1);
            check($sformatf("abort.b%0d_ack", k), ack_done, 0);
            check($sformatf("abort.b%0d_err", k), err, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort.rst_ack", ack_done, 0);
        check("abort.rst_valid", out_valid, 0);
        check("abort.rst_err", err, 0);
        check("abort.rst_last", last, 0);
        check("abort.rst_fail", fail, 0);
        @(negedge clk);
        reset = 1'b0;
        run_case("after_rst", 12'h671, 2'd2, 15'h4200, 1'b0, -1, 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("tail.valid", out_valid, 0);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
